multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
Parameters: none.
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 op  input  7  opcode from instruction register; stable from DECODE until the next FETCH.
REQ-004 zero  input  1  ALU zero flag.
REQ-005 mem_ready  input  1  memory handshake; an access completes in a cycle where it is 1.
REQ-006 pc_write  output  1  PC register load enable.
REQ-007 adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 ir_write  output  1  instruction register (and old-PC register) load enable.
REQ-009 mem_write  output  1  data memory write strobe.
REQ-010 reg_write  output  1  register file write enable.
REQ-011 result_src  output  2  result select: 00 = ALU out register, 01 = read data, 10 = ALU direct.
REQ-012 alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-013 alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-014 alu_op  output  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
REQ-015 imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-017 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-018 Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-type 0010011, beq 1100011, jal 1101111.
REQ-019 FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10; ir_write = pc_write = mem_ready; on mem_ready go to DECODE, otherwise hold.
REQ-020 DECODE: alu_src_a 01, alu_src_b 01, alu_op 00 (branch target precompute).
REQ-021 DECODE next state: lw/sw to MEMADR; R to EXECR; I to EXECI; beq to BEQ; jal to JAL; any other opcode to FETCH with illegal_op = 1.
REQ-022 MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00; go to MEMREAD for lw, MEMWRITE for sw.
REQ-023 MEMREAD: adr_src 1; on mem_ready go to MEMWB, otherwise hold.
REQ-024 MEMWRITE: adr_src 1, mem_write 1 until mem_ready; on mem_ready go to FETCH.
REQ-025 MEMWB: result_src 01, reg_write 1; go to FETCH.
REQ-026 EXECR: alu_src_a 10, alu_src_b 00, alu_op 10; go to ALUWB.
REQ-027 EXECI: alu_src_a 10, alu_src_b 01, alu_op 10; go to ALUWB.
REQ-028 ALUWB: result_src 00, reg_write 1; go to FETCH.
REQ-029 BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00; pc_write = zero; go to FETCH.
REQ-030 JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_write 1; go to ALUWB.
REQ-031 imm_src is a combinational function of op, valid in every state; unlisted opcodes give 00.
REQ-032 All outputs not listed for a state are 0; all outputs are combinational from state, op, zero and mem_ready.
REQ-033 Per-instruction latency with mem_ready always 1: lw 5 cycles; sw, R, I, jal 4; beq 3; illegal 2.

Reset
REQ-034 While rst is 1: state is FETCH, and pc_write, ir_write, mem_write, reg_write and illegal_op are forced to 0.
REQ-035 Reset asserted in any state, including mid-access, aborts the instruction; the first FETCH follows rst deassertion.

Configuration
REQ-036 Macro MC_JAL_EN defined: the JAL state exists and imm_src 11 is produced for jal.
REQ-037 Macro MC_JAL_EN undefined: jal is treated as illegal (DECODE to FETCH, illegal_op pulse) and imm_src returns 00 for it.

Structure
REQ-038 A shared package holds the state enum, the opcode constants, and the encodings for result_src, alu_src_a, alu_src_b, alu_op and imm_src.
REQ-039 A single sub-module, imm_src_decoder (op to imm_src), is instantiated; the FSM is the top level.

Verification
REQ-040 rst pulse mid-MEMREAD, then mem_ready=1 -> state FETCH, no reg_write; ir_write=1 on the first post-reset cycle.
REQ-041 lw (op 0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5 with result_src 01.
REQ-042 sw with mem_ready held 0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, then FETCH.
REQ-043 beq with zero=1 then zero=0 -> pc_write=1 in BEQ for the first and 0 for the second; each 3 cycles.
REQ-044 op 1111111 -> illegal_op=1 for exactly one cycle in DECODE, back to FETCH, no write strobes.
REQ-045 jal with MC_JAL_EN defined -> FETCH, DECODE, JAL (pc_write=1), ALUWB (reg_write=1); undefined -> illegal_op pulse.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
// MC_JAL_EN adds the JAL state and J-type immediate selection.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ
`ifdef MC_JAL_EN
    ,
    S_JAL
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode to immediate-format select; pure combinational.
// J format only exists when MC_JAL_EN is defined.
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    unique case (1'b1)
      (op == OP_SW):  imm_src = IMM_S;
      (op == OP_BEQ): imm_src = IMM_B;
`ifdef MC_JAL_EN
      (op == OP_JAL): imm_src = IMM_J;
`endif
      default:        imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM (lw/sw/R/I/beq, optional jal).
// Define MC_JAL_EN to enable the JAL path; otherwise jal is illegal.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op
);

  state_t state_q, state_d;

  imm_src_decoder u_imm (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (1'b1)
          (op == OP_LW || op == OP_SW): state_d = S_MEMADR;
          (op == OP_R):   state_d = S_EXECR;
          (op == OP_I):   state_d = S_EXECI;
          (op == OP_BEQ): state_d = S_BEQ;
`ifdef MC_JAL_EN
          (op == OP_JAL): state_d = S_JAL;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_READ;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_SUB;
        pc_write  = zero;
        state_d   = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Strobes stay quiet for the whole reset window, not just after the edge.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
